channel_stim_sequencer: RTL

Controller that sequences the NVM flash channel model pipeline (program -> RTN -> CCI -> retention) in hardware.
- Generates pseudo-random 2-bit voltage levels and gates the model pipeline with an enable.
- Discards warm-up outputs and tags each retention-voltage result with the level that produced it.
- Streams (level, voltage) samples out through a valid/ready FIFO for logging or histogramming.
- Replaces testbench-side random-level generation and warm-up skipping; sits between the channel model and any sample consumer.

---
 rtl/channel_seq_pkg.sv | 28 ++
 rtl/channel_stim_sequencer_if.sv | 19 +
 rtl/channel_sample_fifo.sv | 66 ++++++
 rtl/channel_stim_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/channel_seq_pkg.sv
// rtl/channel_seq_pkg.sv - shared types, widths and LFSR helper for channel_stim_sequencer
//
// Purpose : sequencer state encoding, datapath widths, Galois LFSR tap mask
//           and a single-step LFSR function.
// Ports   : none (package).
package channel_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   localparam int LEVEL_W = 2;
   localparam int VOLT_W  = 16;
   localparam int CNT_W   = 20;
   localparam int SMP_W   = LEVEL_W + VOLT_W;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/channel_stim_sequencer_if.sv
// rtl/channel_stim_sequencer_if.sv - sample stream interface (valid/ready, level + voltage)
//
// Purpose : carries FIFO-head samples from the sequencer to a consumer.
// Signals : smp_valid   head sample valid (master -> slave)
//           smp_ready   consumer accepts head (slave -> master)
//           smp_level   level tag of head sample
//           smp_voltage retention voltage of head sample
interface channel_stim_sequencer_if;
   import channel_seq_pkg::*;

   logic                 smp_valid;
   logic                 smp_ready;
   logic [LEVEL_W-1:0]   smp_level;
   logic [VOLT_W-1:0]    smp_voltage;

   modport master (output smp_valid, output smp_level, output smp_voltage, input smp_ready);
   modport slave  (input smp_valid, input smp_level, input smp_voltage, output smp_ready);

endinterface

// File: rtl/channel_sample_fifo.sv
// rtl/channel_sample_fifo.sv - first-word-fall-through sample FIFO
//
// Purpose : stores {level, voltage} samples; head is visible on dout whenever
//           empty is low, one cycle after the push that filled it.
// Ports   : clk, reset (async, active-low)
//           push/din  write one entry (ignored when full)
//           pop       drop the head entry (ignored when empty)
//           dout      head entry
//           full, empty occupancy flags
module channel_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      // simultaneous push and pop leaves the count unchanged
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/channel_stim_sequencer.sv
// rtl/channel_stim_sequencer.sv - sequences the flash channel model and streams tagged samples
//
// Purpose : drives pseudo-random levels into the channel model, discards
//           warm-up results, tags run results with their level and queues
//           them into a FIFO for a downstream consumer.
// Ports   : clk, reset (async, active-low)
//           start            one-cycle pulse, accepted in IDLE or DONE
//           cfg_num_samples  counted samples per run, latched on start
//           model_level      level presented to the channel model
//           model_en         advances the channel model one step
//           model_voltage    model result, LATENCY enabled cycles after its level
//           smp              sample stream (master)
//           busy, done       run status
//           sample_cnt       samples popped in the current run (saturating)
module channel_stim_sequencer
   import channel_seq_pkg::*;
#(
   parameter int          LATENCY    = 8,
   parameter int          WARMUP_CYC = 80,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      cfg_num_samples,
   output logic [LEVEL_W-1:0]    model_level,
   output logic                  model_en,
   input  logic [VOLT_W-1:0]     model_voltage,
   channel_stim_sequencer_if.master smp,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      sample_cnt
);

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   // each stage holds {tag, level}; tag marks results that are to be kept
   logic [LEVEL_W:0]   pipe_q [LATENCY];
   logic [LEVEL_W:0]   pipe_d [LATENCY];

   logic               fifo_full, fifo_empty;
   logic               push, pop;
   logic               drain_complete;
   logic               tag;
   logic [SMP_W-1:0]   fifo_dout;

   assign busy           = (state_q == ST_WARMUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign drain_complete = (state_q == ST_DRAIN) && (cnt_q == CNT_W'(LATENCY));
   assign model_en       = busy && !drain_complete && !fifo_full;
   assign model_level    = busy ? lfsr_q[LEVEL_W-1:0] : '0;
   assign tag            = (state_q == ST_RUN);
   assign push           = model_en && pipe_q[LATENCY-1][LEVEL_W];
   assign pop            = smp.smp_valid && smp.smp_ready;
   assign sample_cnt     = sample_cnt_q;

   assign smp.smp_valid   = !fifo_empty;
   assign smp.smp_level   = fifo_dout[SMP_W-1:VOLT_W];
   assign smp.smp_voltage = fifo_dout[VOLT_W-1:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      num_d        = num_q;
      lfsr_d       = lfsr_q;
      sample_cnt_d = sample_cnt_q;
      pipe_d       = pipe_q;

      if (pop && (sample_cnt_q != {CNT_W{1'b1}}))
         sample_cnt_d = sample_cnt_q + CNT_W'(1);

      // LFSR and tag line only move with the model so stalls lose nothing
      if (model_en) begin
         lfsr_d    = lfsr_step(lfsr_q);
         pipe_d[0] = {tag, lfsr_q[LEVEL_W-1:0]};
         for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_WARMUP;
               cnt_d        = '0;
               num_d        = cfg_num_samples;
               lfsr_d       = LFSR_SEED;
               sample_cnt_d = '0;
            end
         end
         ST_WARMUP: begin
            if (model_en) begin
               if (cnt_q == CNT_W'(WARMUP_CYC - 1)) begin
                  cnt_d   = '0;
                  state_d = (num_q == '0) ? ST_DRAIN : ST_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_RUN: begin
            if (model_en) begin
               if (cnt_q == num_q - CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (model_en) cnt_d = cnt_q + CNT_W'(1);
            if (drain_complete && fifo_empty) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         num_q        <= '0;
         lfsr_q       <= LFSR_SEED;
         sample_cnt_q <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         num_q        <= num_d;
         lfsr_q       <= lfsr_d;
         sample_cnt_q <= sample_cnt_d;
         pipe_q       <= pipe_d;
      end
   end

   channel_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SMP_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({pipe_q[LATENCY-1][LEVEL_W-1:0], model_voltage}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
